// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - host word stream and memory port bundle for program_loader
//
// Purpose: groups the host valid/ready word stream and the unified-memory
// read/write port seen by the program loader.
// Signals:
//   in_valid, in_data   host -> loader word stream
//   in_ready            loader -> host, transfer when in_valid && in_ready
//   mem_addr            loader -> memory, shared write/read address
//   mem_wdata           loader -> memory, write data
//   mem_write           loader -> memory, one-cycle write strobe
//   mem_read            loader -> memory, read strobe
//   mem_rdata           memory -> loader, valid one cycle after mem_read
// Modports: master = loader side, slave = host/memory side.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_addr,
        output mem_wdata,
        output mem_write,
        output mem_read,
        input  mem_rdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_addr,
        input  mem_wdata,
        input  mem_write,
        input  mem_read,
        output mem_rdata
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program image into memory, verifies it by readback sum, then releases the CPU
//
// Purpose: while the CPU is held in reset, accepts load_count words from the
// host stream, writes them to addresses 0..load_count-1, then reads the image
// back and compares a 16-bit modular sum before releasing the CPU.
// Ports:
//   clock       rising-edge clock
//   reset       synchronous, active-high
//   start       one-cycle pulse, honoured only in IDLE/DONE/ERROR
//   load_count  number of words (1..DEPTH), latched on start
//   cpu_hold    1 = CPU held in reset
//   done        image loaded and verified
//   error       bad count or readback mismatch
//   bus         program_loader_if.master: host stream + memory port
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   load_count,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    program_loader_if.master      bus
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << ADDR_WIDTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] chk_q, chk_d;
    // last_q: final word accepted, its write pulse is on the bus this cycle
    logic                  last_q, last_d;
    // rvalid_q: mem_rdata carries the word read in the previous cycle
    logic                  rvalid_q, rvalid_d;
    // cmp_q: chk now holds the full readback sum, compare on this edge
    logic                  cmp_q, cmp_d;
    logic                  in_ready_q, in_ready_d;
    logic                  mem_write_q, mem_write_d;
    logic                  mem_read_q, mem_read_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  count_bad;
    logic [CW-1:0]         wr_ptr_inc;

    assign count_bad  = (load_count == '0) || (load_count > DEPTH_C);
    assign wr_ptr_inc = wr_ptr_q + ONE_C;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sum_d       = sum_q;
        chk_d       = chk_q;
        last_d      = last_q;
        rvalid_d    = rvalid_q;
        cmp_d       = cmp_q;
        in_ready_d  = in_ready_q;
        mem_write_d = 1'b0;
        mem_read_d  = mem_read_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
                    if (count_bad) begin
                        // Illegal count: straight to ERROR, memory untouched.
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d    = S_LOAD;
                        error_d    = 1'b0;
                        count_d    = load_count;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        sum_d      = '0;
                        chk_d      = '0;
                        last_d     = 1'b0;
                        rvalid_d   = 1'b0;
                        cmp_d      = 1'b0;
                        in_ready_d = 1'b1;
                        mem_read_d = 1'b0;
                    end
                end
            end

            S_LOAD: begin
                if (last_q) begin
                    // Final write pulse is visible now; first read follows it directly.
                    state_d    = S_CHECK;
                    last_d     = 1'b0;
                    mem_read_d = 1'b1;
                    mem_addr_d = '0;
                    rd_ptr_d   = ONE_C;
                end else if (bus.in_valid && in_ready_q) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = wr_ptr_q[ADDR_WIDTH-1:0];
                    mem_wdata_d = bus.in_data;
                    wr_ptr_d    = wr_ptr_inc;
                    sum_d       = sum_q + bus.in_data;
                    if (wr_ptr_inc == count_q) begin
                        in_ready_d = 1'b0;
                        last_d     = 1'b1;
                    end
                end
            end

            S_CHECK: begin
                rvalid_d = mem_read_q;
                if (mem_read_q) begin
                    if (rd_ptr_q == count_q) begin
                        mem_read_d = 1'b0;
                    end else begin
                        mem_addr_d = rd_ptr_q[ADDR_WIDTH-1:0];
                        rd_ptr_d   = rd_ptr_q + ONE_C;
                    end
                end
                if (rvalid_q) begin
                    chk_d = chk_q + bus.mem_rdata;
                    // Reads are contiguous, so data arriving after the strobe
                    // has dropped is the last word of the image.
                    if (!mem_read_q) begin
                        cmp_d = 1'b1;
                    end
                end
                if (cmp_q) begin
                    cmp_d = 1'b0;
                    if (chk_q == sum_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = S_ERROR;
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sum_q       <= '0;
            chk_q       <= '0;
            last_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            cmp_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sum_q       <= sum_d;
            chk_q       <= chk_d;
            last_q      <= last_d;
            rvalid_q    <= rvalid_d;
            cmp_q       <= cmp_d;
            in_ready_q  <= in_ready_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_hold      = cpu_hold_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic [8:0]  load_count;
    logic        cpu_hold;
    logic        done;
    logic        error;

    program_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .load_count (load_count),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .bus        (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ideal memory with optional corruption of address 1 on readback.
    logic [15:0] mem [0:255];
    bit          corrupt = 1'b0;

    // Bus monitor state.
    int          cyc = 0;
    int          n_wr, n_rd;
    int          last_wr_cyc, first_rd_cyc, done_cyc;
    logic [7:0]  wr_addr_log [$];
    logic [15:0] wr_data_log [$];
    logic [7:0]  rd_addr_log [$];

    always @(posedge clock) begin
        cyc++;
        if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            n_wr++;
            last_wr_cyc = cyc;
            wr_addr_log.push_back(bus.mem_addr);
            wr_data_log.push_back(bus.mem_wdata);
        end
        if (bus.mem_read) begin
            bus.mem_rdata <= (corrupt && bus.mem_addr == 8'd1) ? 16'h0000 : mem[bus.mem_addr];
            n_rd++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
            rd_addr_log.push_back(bus.mem_addr);
        end
        if (done && done_cyc < 0) done_cyc = cyc;
    end

    logic [15:0] wv [0:7];
    int          ready_drops;

    task automatic clear_logs();
        n_wr = 0;
        n_rd = 0;
        last_wr_cyc  = -1;
        first_rd_cyc = -1;
        done_cyc     = -1;
        ready_drops  = 0;
        wr_addr_log.delete();
        wr_data_log.delete();
        rd_addr_log.delete();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [8:0] cnt);
        start = 1'b1;
        load_count = cnt;
        tick();
        start = 1'b0;
    endtask

    task automatic send_words(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                bus.in_valid = 1'b0;
                if (!bus.in_ready) ready_drops++;
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = wv[i];
            if (!bus.in_ready) ready_drops++;
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(done || error) && k < 1000) begin
            tick();
            k++;
        end
        check_eq({tag, "_timeout"}, 32'(k >= 1000), 32'd0);
        tick();
    endtask

    task automatic check_writes(input string tag, input int n);
        check_eq({tag, "_nwr"}, 32'(n_wr), 32'(n));
        for (int i = 0; i < wr_addr_log.size() && i < n; i++) begin
            check_eq({tag, "_wr_addr"}, 32'(wr_addr_log[i]), 32'(i));
            check_eq({tag, "_wr_data"}, 32'(wr_data_log[i]), 32'(wv[i]));
        end
    endtask

    task automatic check_reads(input string tag, input int n);
        check_eq({tag, "_nrd"}, 32'(n_rd), 32'(n));
        for (int i = 0; i < rd_addr_log.size() && i < n; i++) begin
            check_eq({tag, "_rd_addr"}, 32'(rd_addr_log[i]), 32'(i));
        end
        check_eq({tag, "_chk_entry"}, 32'(first_rd_cyc - last_wr_cyc), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        load_count = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        clear_logs();

        // 1: reset state
        tick();
        tick();
        check_eq("rst_hold",     32'(cpu_hold),      32'd1);
        check_eq("rst_ready",    32'(bus.in_ready),  32'd0);
        check_eq("rst_write",    32'(bus.mem_write), 32'd0);
        check_eq("rst_read",     32'(bus.mem_read),  32'd0);
        check_eq("rst_addr",     32'(bus.mem_addr),  32'd0);
        check_eq("rst_done",     32'(done),          32'd0);
        check_eq("rst_error",    32'(error),         32'd0);
        reset = 1'b0;
        tick();

        // 2: three words back-to-back, sum wraps to 0x1234
        wv[0] = 16'h1234; wv[1] = 16'h0001; wv[2] = 16'hFFFF;
        pulse_start(9'd3);
        clear_logs();
        check_eq("t2_ready", 32'(bus.in_ready), 32'd1);
        send_words(3, 1'b0);
        check_eq("t2_ready_drop", 32'(bus.in_ready), 32'd0);
        wait_end("t2");
        check_writes("t2", 3);
        check_reads("t2", 3);
        check_eq("t2_done",    32'(done),     32'd1);
        check_eq("t2_error",   32'(error),    32'd0);
        check_eq("t2_hold",    32'(cpu_hold), 32'd0);
        check_eq("t2_latency", 32'(done_cyc - first_rd_cyc), 32'd5);

        // 3: four words with idle gaps, started from DONE
        wv[0] = 16'hA000; wv[1] = 16'h0B00; wv[2] = 16'h00C0; wv[3] = 16'h000D;
        pulse_start(9'd4);
        clear_logs();
        check_eq("t3_rehold", 32'(cpu_hold), 32'd1);
        check_eq("t3_undone", 32'(done),     32'd0);
        send_words(4, 1'b1);
        check_eq("t3_ready_steady", 32'(ready_drops), 32'd0);
        wait_end("t3");
        check_writes("t3", 4);
        check_reads("t3", 4);
        check_eq("t3_done",    32'(done), 32'd1);
        check_eq("t3_latency", 32'(done_cyc - first_rd_cyc), 32'd6);

        // 4: corrupted readback of the test 2 image
        wv[0] = 16'h1234; wv[1] = 16'h0001; wv[2] = 16'hFFFF;
        pulse_start(9'd3);
        clear_logs();
        corrupt = 1'b1;
        send_words(3, 1'b0);
        wait_end("t4");
        corrupt = 1'b0;
        check_writes("t4", 3);
        check_eq("t4_nrd",   32'(n_rd),     32'd3);
        check_eq("t4_error", 32'(error),    32'd1);
        check_eq("t4_done",  32'(done),     32'd0);
        check_eq("t4_hold",  32'(cpu_hold), 32'd1);

        // 5: illegal counts 0 and 257
        reset = 1'b1; tick(); reset = 1'b0; tick();
        clear_logs();
        pulse_start(9'd0);
        check_eq("t5_zero_error", 32'(error), 32'd1);
        repeat (4) tick();
        reset = 1'b1; tick(); reset = 1'b0; tick();
        check_eq("t5_cleared", 32'(error), 32'd0);
        pulse_start(9'd257);
        check_eq("t5_big_error", 32'(error), 32'd1);
        check_eq("t5_big_ready", 32'(bus.in_ready), 32'd0);
        repeat (4) tick();
        check_eq("t5_nwr", 32'(n_wr), 32'd0);
        check_eq("t5_nrd", 32'(n_rd), 32'd0);

        // 6: reset after two of four words, reset beats a simultaneous start
        wv[0] = 16'h0102; wv[1] = 16'h0304; wv[2] = 16'h0506; wv[3] = 16'h0708;
        pulse_start(9'd4);
        clear_logs();
        send_words(2, 1'b0);
        reset = 1'b1;
        start = 1'b1;
        load_count = 9'd2;
        bus.in_valid = 1'b1;
        bus.in_data  = wv[2];
        tick();
        check_eq("t6_rst_ready", 32'(bus.in_ready),  32'd0);
        check_eq("t6_rst_write", 32'(bus.mem_write), 32'd0);
        check_eq("t6_rst_hold",  32'(cpu_hold),      32'd1);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check_eq("t6_start_ignored", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        check_eq("t6_nwr_partial", 32'(n_wr), 32'd2);
        check_eq("t6_mem1", 32'(mem[1]), 32'h0304);
        pulse_start(9'd2);
        clear_logs();
        wv[0] = 16'h1111; wv[1] = 16'h2222;
        send_words(2, 1'b0);
        wait_end("t6");
        check_writes("t6", 2);
        check_eq("t6_done", 32'(done), 32'd1);
        check_eq("t6_hold", 32'(cpu_hold), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
